// File: rtl/mips_pkg.sv
// mips_pkg: fetch FSM encoding, opcode constants and reset PC shared by the
// fetch stage and the control unit.
package mips_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
  localparam logic [5:0] rType         = 6'h00;
  localparam logic [5:0] loadWord      = 6'h23;
  localparam logic [5:0] storeWord     = 6'h2b;
  localparam logic [5:0] addImmediate  = 6'h08;
  localparam logic [5:0] branchIfEqual = 6'h04;
  localparam logic [5:0] jump_inst     = 6'h02;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/next_pc_logic.sv
// next_pc_logic: combinational next-PC selection, jump over branch over sequential.
module next_pc_logic (
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic [31:0] sign_imm,
  input  logic        pc_src,
  input  logic        jmp,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);
  logic unused_opcode;
  assign unused_opcode = ^instruction[31:26];
  assign pc_plus4 = pc + 32'd4;
  assign next_pc = jmp    ? {pc_plus4[31:28], instruction[25:0], 2'b00} :
                   pc_src ? pc_plus4 + (sign_imm << 2) :
                            pc_plus4;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and instruction fetcher; IDLE -> FETCH -> EXEC loop
// with retired-instruction counting.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             ImemReq,
  output logic [31:0]      ImemAddr,
  input  logic             ImemReady,
  input  logic [31:0]      ImemRdata,
  output logic [31:0]      Instruction,
  output logic             InstrValid,
  input  logic             Retire,
  input  logic             PCSrc,
  input  logic             Jmp,
  input  logic [31:0]      SignImm,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic [CNT_W-1:0] RetiredCount
);
  state_t state;
  logic [31:0] next_pc;
  next_pc_logic u_next_pc (
    .pc          (PC),
    .instruction (Instruction),
    .sign_imm    (SignImm),
    .pc_src      (PCSrc),
    .jmp         (Jmp),
    .pc_plus4    (PCPlus4),
    .next_pc     (next_pc)
  );
  assign ImemAddr = PC;
  // ImemReq/InstrValid are registered alongside state so they never follow inputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      PC           <= RESET_PC;
      Instruction  <= '0;
      RetiredCount <= '0;
      ImemReq      <= 1'b0;
      InstrValid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= FETCH;
          ImemReq <= 1'b1;
        end
        FETCH: if (ImemReady) begin
          Instruction <= ImemRdata;
          state       <= EXEC;
          ImemReq     <= 1'b0;
          InstrValid  <= 1'b1;
        end
        EXEC: if (Retire) begin
          PC           <= next_pc;
          RetiredCount <= RetiredCount + CNT_W'(1);
          state        <= FETCH;
          ImemReq      <= 1'b1;
          InstrValid   <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          ImemReq    <= 1'b0;
          InstrValid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table, randomized instruction stream
// against a reference PC model, and asynchronous reset corner cases.
module tb_instr_fetch_unit;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady = 1'b0;
  logic [31:0] ImemRdata = '0;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        Retire = 1'b0;
  logic        PCSrc = 1'b0;
  logic        Jmp = 1'b0;
  logic [31:0] SignImm = '0;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] RetiredCount;

  int checks = 0;
  int errors = 0;
  logic [31:0] pc_m;
  logic [31:0] cnt_m;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] simm;
    logic        pcsrc;
    logic        jmp;
    int          waits;
    int          rdelay;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs [6];

  instr_fetch_unit dut (
    .CLK          (CLK),
    .RST          (RST),
    .ImemReq      (ImemReq),
    .ImemAddr     (ImemAddr),
    .ImemReady    (ImemReady),
    .ImemRdata    (ImemRdata),
    .Instruction  (Instruction),
    .InstrValid   (InstrValid),
    .Retire       (Retire),
    .PCSrc        (PCSrc),
    .Jmp          (Jmp),
    .SignImm      (SignImm),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .RetiredCount (RetiredCount)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural rule: jump target keeps the top nibble of PC+4, branch adds the
  // word-scaled immediate, otherwise fall through; everything modulo 2^32.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] instr,
                                           input logic [31:0] simm, input logic pcsrc, input logic jmp);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (jmp) return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    if (pcsrc) return seq + simm * 32'd4;
    return seq;
  endfunction

  // Starts with the DUT in its first FETCH cycle for pc_m; ends in the next FETCH.
  task automatic run_instr(input logic [31:0] rdata, input logic [31:0] simm, input logic pcsrc,
                           input logic jmp, input int waits, input int rdelay, input logic [31:0] exp_pc);
    for (int w = 0; w < waits; w++) begin
      ImemReady = 1'b0;
      ImemRdata = $urandom;
      Retire = 1'b1;
      PCSrc = 1'($urandom);
      Jmp = 1'($urandom);
      SignImm = $urandom;
      tick();
      chk("wait_req", ImemReq, 1);
      chk("wait_addr", ImemAddr, pc_m);
      chk("wait_valid", InstrValid, 0);
      chk("wait_cnt", RetiredCount, cnt_m);
    end
    ImemReady = 1'b1;
    ImemRdata = rdata;
    Retire = 1'b0;
    tick();
    chk("fetch_instr", Instruction, rdata);
    chk("fetch_valid", InstrValid, 1);
    chk("fetch_req", ImemReq, 0);
    for (int d = 0; d < rdelay; d++) begin
      ImemReady = 1'b1;
      ImemRdata = $urandom;
      PCSrc = 1'($urandom);
      Jmp = 1'($urandom);
      tick();
      chk("hold_instr", Instruction, rdata);
      chk("hold_pc", PC, pc_m);
      chk("hold_valid", InstrValid, 1);
    end
    ImemReady = 1'b0;
    Retire = 1'b1;
    PCSrc = pcsrc;
    Jmp = jmp;
    SignImm = simm;
    #1;
    chk("pcplus4", PCPlus4, pc_m + 32'd4);
    tick();
    cnt_m = cnt_m + 32'd1;
    pc_m = exp_pc;
    chk("retire_pc", PC, pc_m);
    chk("retire_cnt", RetiredCount, cnt_m);
    chk("retire_req", ImemReq, 1);
    chk("retire_addr", ImemAddr, pc_m);
    chk("retire_valid", InstrValid, 0);
    Retire = 1'b0;
    PCSrc = 1'b0;
    Jmp = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h0800_0004, 32'h0000_0000, 1'b0, 1'b1, 0, 0, 32'h0000_0010};
    vecs[1] = '{32'h1000_FFFF, 32'hFFFF_FFFC, 1'b1, 1'b0, 3, 1, 32'h0000_0004};
    vecs[2] = '{32'h2008_0005, 32'h0400_0000, 1'b1, 1'b0, 1, 0, 32'h1000_0008};
    vecs[3] = '{32'h0800_0040, 32'h0000_1234, 1'b1, 1'b1, 0, 2, 32'h1000_0100};
    vecs[4] = '{32'h1000_0000, 32'h3BFF_FFBE, 1'b1, 1'b0, 0, 0, 32'hFFFF_FFFC};
    vecs[5] = '{32'h0000_0020, 32'hFFFF_FFFF, 1'b0, 1'b0, 2, 0, 32'h0000_0000};

    repeat (2) tick();
    chk("rst_req", ImemReq, 0);
    chk("rst_valid", InstrValid, 0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_cnt", RetiredCount, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    RST = 1'b0;
    #1;
    chk("idle_req", ImemReq, 0);
    tick();
    chk("start_req", ImemReq, 1);
    chk("start_addr", ImemAddr, 32'h0);
    ImemReady = 1'b1;
    ImemRdata = 32'h2008_0005;
    tick();
    chk("start_instr", Instruction, 32'h2008_0005);
    chk("start_valid", InstrValid, 1);
    ImemReady = 1'b0;
    Retire = 1'b1;
    tick();
    Retire = 1'b0;
    chk("seq_pc", PC, 32'h4);
    chk("seq_cnt", RetiredCount, 32'h1);
    chk("seq_req", ImemReq, 1);
    chk("seq_addr", ImemAddr, 32'h4);
    pc_m = 32'h4;
    cnt_m = 32'h1;

    for (int i = 0; i < 6; i++)
      run_instr(vecs[i].rdata, vecs[i].simm, vecs[i].pcsrc, vecs[i].jmp,
                vecs[i].waits, vecs[i].rdelay, vecs[i].exp_pc);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] rd, si;
      logic bs, jp;
      rd = $urandom;
      si = $urandom;
      bs = 1'($urandom);
      jp = ($urandom_range(0, 3) == 0);
      run_instr(rd, si, bs, jp, $urandom_range(0, 2), $urandom_range(0, 2),
                ref_next(pc_m, rd, si, bs, jp));
    end

    ImemReady = 1'b1;
    ImemRdata = 32'hDEAD_BEEF;
    tick();
    ImemReady = 1'b0;
    chk("pre_rst_valid", InstrValid, 1);
    #2;
    RST = 1'b1;
    #1;
    chk("async_valid", InstrValid, 0);
    chk("async_req", ImemReq, 0);
    chk("async_pc", PC, 32'h0);
    chk("async_cnt", RetiredCount, 32'h0);
    tick();
    RST = 1'b0;
    #1;
    chk("restart_idle_req", ImemReq, 0);
    tick();
    chk("restart_req", ImemReq, 1);
    chk("restart_addr", ImemAddr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
